// File: rtl/mem_pkg.sv
// Shared types, constants and helpers for the word-addressed memory responder.
// The optional alignment check in mem_responder is enabled by MEM_ALIGN_CHECK_EN.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;
    localparam int          CNT_W     = 4;

    // Uses the whole word address so high addresses cannot alias into the array.
    function automatic logic in_range(input logic [31:0] adr, input int unsigned depth);
        return (adr >> 2) < depth;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word memory: synchronous write, synchronous registered read.
// The read register holds its value until the next read or clear.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic          rclr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rclr) begin
            rdata <= ERR_RDATA;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the multicycle processor's shared port: accepts one request,
// waits WAIT_STATES cycles, performs the access and pulses MemReady. Macro: MEM_ALIGN_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr,
    output mem_state_t  dbg_state
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Handshake: a request is taken on any edge where MemReq=1 and the FSM is in IDLE
    // or RESP; inputs are ignored otherwise. Completion is the single RESP cycle in
    // which MemReady=1; MemErr and ReadData are meaningful in that cycle.

    mem_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic            accept;
    logic            do_access;

    logic            write_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            adr_misaligned;
    logic            req_err;

`ifdef MEM_ALIGN_CHECK_EN
    assign adr_misaligned = |Adr[1:0];
`else
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^Adr[1:0];
    assign adr_misaligned = 1'b0;
`endif

    assign req_err = !in_range(Adr, DEPTH_WORDS) || adr_misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (MemReq) begin
                    accept = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (MemReq) begin
                    accept = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (accept) begin
            state_next = BUSY;
            cnt_next   = CNT_W'(WAIT_STATES);
        end
    end

    // Error status is resolved at acceptance so the commit edge only needs a flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= MemWrite;
            err_q   <= req_err;
            idx_q   <= Adr[AW+1:2];
            wdata_q <= WriteData;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (reset),
        .we    (do_access && write_q && !err_q),
        .re    (do_access && !write_q && !err_q),
        .rclr  (do_access && !write_q && err_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ReadData)
    );

    assign MemReady  = (state == RESP);
    assign MemErr    = (state == RESP) && err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_WORDS=64, WAIT_STATES=2); honours MEM_ALIGN_CHECK_EN.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;
    mem_state_t  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder #(
        .DEPTH_WORDS (64),
        .WAIT_STATES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .MemReady  (MemReady),
        .MemErr    (MemErr),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d);
        MemReq    = 1'b1;
        MemWrite  = w;
        Adr       = a;
        WriteData = d;
    endtask

    // Counts edges from request presentation until MemReady is seen (-1 on timeout).
    task automatic finish_req(output int cyc, output logic [31:0] rd, output logic err);
        cyc = -1;
        rd  = 'x;
        err = 1'bx;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) MemReq = 1'b0;
            if (MemReady) begin
                cyc = k;
                rd  = ReadData;
                err = MemErr;
                break;
            end
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int cyc, output logic [31:0] rd, output logic err);
        start_req(w, a, d);
        finish_req(cyc, rd, err);
        @(posedge clk);
        #1;
    endtask

    int          cyc;
    logic [31:0] rd;
    logic        err;
    int          nready;
    int          ready_k [4];
    logic [31:0] ready_d [4];
    logic        saw_idle;
    logic        ready_during_rst;
    logic [31:0] b2b_adr [3];

    initial begin
        reset     = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        Adr       = '0;
        WriteData = '0;

        // reset with a request pending: nothing happens until release
        start_req(1'b1, 32'h0, 32'h1234_5678);
        repeat (3) @(posedge clk);
        #1;
        check32("rst_ready", 32'(MemReady), 32'd0);
        check32("rst_rdata", ReadData, 32'h0);
        check32("rst_err", 32'(MemErr), 32'd0);
        check32("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        finish_req(cyc, rd, err);
        check32("first_accept_latency", 32'(cyc), 32'd4);
        check32("first_accept_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // write then read, 2 wait states
        access(1'b1, 32'h10, 32'hCAFE_F00D, cyc, rd, err);
        check32("wr10_latency", 32'(cyc), 32'd4);
        check32("wr10_err", 32'(err), 32'd0);
        access(1'b0, 32'h10, 32'h0, cyc, rd, err);
        check32("rd10_latency", 32'(cyc), 32'd4);
        check32("rd10_data", rd, 32'hCAFE_F00D);
        check32("rd10_err", 32'(err), 32'd0);
        check32("rd10_hold", ReadData, 32'hCAFE_F00D);
        check32("ready_one_cycle", 32'(MemReady), 32'd0);

        // back-to-back reads with MemReq held through RESP
        access(1'b1, 32'h4, 32'h1111_0001, cyc, rd, err);
        access(1'b1, 32'h8, 32'h2222_0002, cyc, rd, err);
        b2b_adr[0] = 32'h0;
        b2b_adr[1] = 32'h4;
        b2b_adr[2] = 32'h8;
        start_req(1'b0, b2b_adr[0], 32'h0);
        nready   = 0;
        saw_idle = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k <= 12 && dbg_state == IDLE) saw_idle = 1'b1;
            if (k == 9) MemReq = 1'b0;
            if (MemReady && nready < 4) begin
                ready_k[nready] = k;
                ready_d[nready] = ReadData;
                nready++;
                if (nready < 3) Adr = b2b_adr[nready];
            end
        end
        check32("b2b_count", 32'(nready), 32'd3);
        check32("b2b_k0", 32'(ready_k[0]), 32'd4);
        check32("b2b_k1", 32'(ready_k[1]), 32'd8);
        check32("b2b_k2", 32'(ready_k[2]), 32'd12);
        check32("b2b_d0", ready_d[0], 32'h1234_5678);
        check32("b2b_d1", ready_d[1], 32'h1111_0001);
        check32("b2b_d2", ready_d[2], 32'h2222_0002);
        check32("b2b_no_idle", 32'(saw_idle), 32'd0);

        // range checks
        access(1'b1, 32'h100, 32'h1111_1111, cyc, rd, err);
        check32("oor_wr_err", 32'(err), 32'd1);
        check32("oor_wr_latency", 32'(cyc), 32'd4);
        check32("err_only_in_resp", 32'(MemErr), 32'd0);
        access(1'b0, 32'h0, 32'h0, cyc, rd, err);
        check32("word0_kept", rd, 32'h1234_5678);
        check32("word0_err", 32'(err), 32'd0);
        access(1'b0, 32'h100, 32'h0, cyc, rd, err);
        check32("oor_rd_data", rd, 32'h0);
        check32("oor_rd_err", 32'(err), 32'd1);
        access(1'b0, 32'h0, 32'h0, cyc, rd, err);
        access(1'b0, 32'h1000_0000, 32'h0, cyc, rd, err);
        check32("high_rd_data", rd, 32'h0);
        check32("high_rd_err", 32'(err), 32'd1);
        access(1'b1, 32'hFC, 32'h3F3F_003F, cyc, rd, err);
        check32("last_wr_err", 32'(err), 32'd0);
        access(1'b0, 32'hFC, 32'h0, cyc, rd, err);
        check32("last_rd_data", rd, 32'h3F3F_003F);

        // reset one cycle after accepting a write
        access(1'b1, 32'h20, 32'h0BAD_0020, cyc, rd, err);
        start_req(1'b1, 32'h20, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        MemReq = 1'b0;
        check32("midbusy_state", 32'(dbg_state), 32'(BUSY));
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check32("midrst_state", 32'(dbg_state), 32'(IDLE));
        ready_during_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (MemReady) ready_during_rst = 1'b1;
        end
        check32("midrst_no_ready", 32'(ready_during_rst), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 32'h20, 32'h0, cyc, rd, err);
        check32("midrst_old_data", rd, 32'h0BAD_0020);
        check32("midrst_rd_latency", 32'(cyc), 32'd4);

        // misaligned read of word 4
        access(1'b0, 32'h13, 32'h0, cyc, rd, err);
        check32("align_latency", 32'(cyc), 32'd4);
`ifdef MEM_ALIGN_CHECK_EN
        check32("align_err", 32'(err), 32'd1);
        check32("align_data", rd, 32'h0);
`else
        check32("align_err", 32'(err), 32'd0);
        check32("align_data", rd, 32'hCAFE_F00D);
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
